// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write port, FIFO status and serial line of the buffered UART transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic                          uart_wr_i;
  logic [DATA_BITS-1:0]          uart_dat_i;
  logic                          uart_full_o;
  logic                          uart_empty_o;
  logic [$clog2(FIFO_DEPTH):0]   uart_level_o;
  logic                          uart_busy_o;
  logic                          uart_ovf_o;
  logic                          uart_tx_o;
  modport master (
    output uart_wr_i, uart_dat_i,
    input  uart_full_o, uart_empty_o, uart_level_o, uart_busy_o, uart_ovf_o, uart_tx_o
  );
  modport slave (
    input  uart_wr_i, uart_dat_i,
    output uart_full_o, uart_empty_o, uart_level_o, uart_busy_o, uart_ovf_o, uart_tx_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a circular FIFO, frames sent back-to-back.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 3000000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_ni,
  uart_tx_fifo_if.slave bus
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int ACC_W = $clog2(CLK_HZ) + 1;
  localparam int NBITS = 1 + DATA_BITS + (PARITY != 0 ? 1 : 0) + STOP_BITS;
  localparam int FW    = DATA_BITS + STOP_BITS + 2;
  localparam int CW    = $clog2(NBITS + 1);
  localparam logic [ACC_W-1:0] BAUD_INC = ACC_W'(BAUD);
  localparam logic [ACC_W-1:0] CLK_MOD  = ACC_W'(CLK_HZ);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  logic [ACC_W-1:0]     acc, acc_sum;
  logic                 tick;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wp, rp;
  logic                 full, empty, push, pop, par, tx, ovf;
  logic [0:0]           state;
  logic [CW-1:0]        bitcnt;
  logic [DATA_BITS-1:0] head;
  logic [FW-1:0]        frame;
  logic [FW-2:0]        sh;
  // frame is always FW wide; without parity the spare top bit is one more idle-high stop bit that is never sent
  always_comb begin
    acc_sum = acc + BAUD_INC;
    tick    = acc_sum >= CLK_MOD;
    empty   = wp == rp;
    full    = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    push    = bus.uart_wr_i && !full;
    pop     = tick && !empty && (state == IDLE || bitcnt == CW'(1));
    head    = mem[rp[AW-1:0]];
    par     = ^head ^ (PARITY == 1);
    frame   = PARITY != 0 ? {{STOP_BITS{1'b1}}, par, head, 1'b0}
                          : {{(STOP_BITS + 1){1'b1}}, head, 1'b0};
  end
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni)
    if (!sys_rst_ni) begin
      acc    <= '0;
      wp     <= '0;
      rp     <= '0;
      ovf    <= 1'b0;
      state  <= IDLE;
      bitcnt <= '0;
      sh     <= '1;
      tx     <= 1'b1;
    end else begin
      acc <= tick ? acc_sum - CLK_MOD : acc_sum;
      wp  <= wp + PW'(push);
      rp  <= rp + PW'(pop);
      ovf <= ovf | (bus.uart_wr_i & full);
      if (pop) begin
        state  <= SEND;
        sh     <= frame[FW-1:1];
        tx     <= frame[0];
        bitcnt <= CW'(NBITS);
      end else if (tick && state == SEND && bitcnt == CW'(1)) begin
        state <= IDLE;
      end else if (tick && state == SEND) begin
        sh     <= {1'b1, sh[FW-2:1]};
        tx     <= sh[0];
        bitcnt <= bitcnt - CW'(1);
      end
    end
  always_ff @(posedge sys_clk_i)
    if (push) mem[wp[AW-1:0]] <= bus.uart_dat_i;
  assign bus.uart_full_o  = full;
  assign bus.uart_empty_o = empty;
  assign bus.uart_level_o = wp - rp;
  assign bus.uart_busy_o  = state == SEND || !empty;
  assign bus.uart_ovf_o   = ovf;
  assign bus.uart_tx_o    = tx;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, FIFO status, burst, baud jitter and async reset.
module tb_uart_tx_fifo;
  logic sys_clk_i = 1'b0;
  logic sys_rst_ni = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] v;
  always #5 sys_clk_i = ~sys_clk_i;
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) b0 ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(16)) b1 ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(16)) b2 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) b3 ();
  uart_tx_fifo d0 (.sys_clk_i(sys_clk_i), .sys_rst_ni(sys_rst_ni), .bus(b0.slave));
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) d1 (
    .sys_clk_i(sys_clk_i), .sys_rst_ni(sys_rst_ni), .bus(b1.slave));
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) d2 (
    .sys_clk_i(sys_clk_i), .sys_rst_ni(sys_rst_ni), .bus(b2.slave));
  uart_tx_fifo #(.BAUD(115200)) d3 (.sys_clk_i(sys_clk_i), .sys_rst_ni(sys_rst_ni), .bus(b3.slave));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic txs(input int s);
    return s == 0 ? b0.uart_tx_o : s == 1 ? b1.uart_tx_o : s == 2 ? b2.uart_tx_o : b3.uart_tx_o;
  endfunction
  task automatic wait_start(input int s, input int bound, input string tag);
    int n = 0;
    while (txs(s) !== 1'b0 && n < bound) begin
      @(negedge sys_clk_i);
      n++;
    end
    chk(tag, txs(s), 0);
  endtask
  // called on the first negedge of a start bit; returns there for the next frame's start
  task automatic grab(input int s, input int bc, input int nb, output logic [15:0] q);
    int t = 0;
    q = '0;
    for (int b = 0; b < nb; b++) begin
      while (t < b * bc + bc / 2) begin
        @(negedge sys_clk_i);
        t++;
      end
      q[b] = txs(s);
    end
    while (t < nb * bc) begin
      @(negedge sys_clk_i);
      t++;
    end
  endtask
  initial begin
    logic [39:0] obs, exp40;
    logic [9:0] fr;
    int last, n, t, lows;
    logic prev;
    b0.uart_wr_i = 0; b0.uart_dat_i = '0;
    b1.uart_wr_i = 0; b1.uart_dat_i = '0;
    b2.uart_wr_i = 0; b2.uart_dat_i = '0;
    b3.uart_wr_i = 0; b3.uart_dat_i = '0;
    repeat (3) @(negedge sys_clk_i);
    chk("rst_tx", b0.uart_tx_o, 1);
    chk("rst_busy", b0.uart_busy_o, 0);
    chk("rst_full", b0.uart_full_o, 0);
    chk("rst_empty", b0.uart_empty_o, 1);
    chk("rst_level", b0.uart_level_o, 0);
    chk("rst_ovf", b0.uart_ovf_o, 0);
    chk("rst_tx3", b3.uart_tx_o, 1);
    sys_rst_ni = 1'b1;
    repeat (2) @(negedge sys_clk_i);
    // single 8'hA5 frame, 4 cycles per bit
    b0.uart_wr_i = 1; b0.uart_dat_i = 8'hA5;
    @(negedge sys_clk_i);
    b0.uart_wr_i = 0;
    chk("wr_level", b0.uart_level_o, 1);
    chk("wr_empty", b0.uart_empty_o, 0);
    chk("wr_busy", b0.uart_busy_o, 1);
    wait_start(0, 8, "a5_start");
    chk("a5_level0", b0.uart_level_o, 0);
    fr = 10'b1101001010;
    for (int i = 0; i < 40; i++) begin
      exp40[i] = fr[i / 4];
      obs[i] = b0.uart_tx_o;
      if (i == 39) chk("a5_busy39", b0.uart_busy_o, 1);
      @(negedge sys_clk_i);
    end
    chk("a5_bits", obs, exp40);
    chk("a5_busy40", b0.uart_busy_o, 0);
    chk("a5_idle", b0.uart_tx_o, 1);
    // one frame in flight, then a 20-word burst: 16 fit, 4 dropped
    @(negedge sys_clk_i);
    b0.uart_wr_i = 1; b0.uart_dat_i = 8'h3C;
    @(negedge sys_clk_i);
    b0.uart_wr_i = 0;
    wait_start(0, 8, "burst_start");
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          b0.uart_wr_i = 1; b0.uart_dat_i = 8'(i * 37 + 1);
          @(negedge sys_clk_i);
          if (i == 14) chk("full_15", b0.uart_full_o, 0);
          if (i == 15) begin
            chk("full_16", b0.uart_full_o, 1);
            chk("level_16", b0.uart_level_o, 16);
            chk("ovf_16", b0.uart_ovf_o, 0);
          end
          if (i == 16) chk("ovf_17", b0.uart_ovf_o, 1);
        end
        b0.uart_wr_i = 0;
      end
      for (int f = 0; f < 17; f++) begin
        grab(0, 4, 10, v);
        chk($sformatf("frame%0d", f), v, {1'b1, f == 0 ? 8'h3C : 8'((f - 1) * 37 + 1), 1'b0});
      end
    join
    chk("burst_busy", b0.uart_busy_o, 0);
    chk("burst_empty", b0.uart_empty_o, 1);
    chk("ovf_sticky", b0.uart_ovf_o, 1);
    // 7E2 and 7O2 with 7'h55
    b1.uart_wr_i = 1; b1.uart_dat_i = 7'h55;
    @(negedge sys_clk_i);
    b1.uart_wr_i = 0;
    wait_start(1, 8, "even_start");
    grab(1, 4, 11, v);
    chk("even_frame", v, 11'b11010101010);
    chk("even_len", b1.uart_busy_o, 0);
    b2.uart_wr_i = 1; b2.uart_dat_i = 7'h55;
    @(negedge sys_clk_i);
    b2.uart_wr_i = 0;
    wait_start(2, 8, "odd_start");
    grab(2, 4, 11, v);
    chk("odd_frame", v, 11'b11110101010);
    chk("odd_len", b2.uart_busy_o, 0);
    // 115200 baud: alternating bits expose every bit boundary
    b3.uart_wr_i = 1; b3.uart_dat_i = 8'h55;
    @(negedge sys_clk_i);
    b3.uart_wr_i = 0;
    wait_start(3, 130, "b115_start");
    last = 0; n = 0; t = 0; prev = 1'b0;
    while (b3.uart_busy_o && t < 2000) begin
      @(negedge sys_clk_i);
      t++;
      if (b3.uart_tx_o !== prev) begin
        chk($sformatf("ivl%0d_%0d", n, t - last), (t - last == 104) || (t - last == 105), 1);
        last = t;
        prev = b3.uart_tx_o;
        n++;
      end
    end
    chk("b115_ntrans", n, 9);
    chk($sformatf("b115_span_%0d", t), (t == 1041) || (t == 1042), 1);
    // reset in the middle of a frame with 3 words still queued
    for (int i = 0; i < 4; i++) begin
      b0.uart_wr_i = 1; b0.uart_dat_i = 8'(8'h10 + i);
      @(negedge sys_clk_i);
    end
    b0.uart_wr_i = 0;
    wait_start(0, 8, "rst_start");
    chk("rst_queued", b0.uart_level_o, 3);
    repeat (10) @(negedge sys_clk_i);
    #2 sys_rst_ni = 1'b0;
    #1;
    chk("arst_tx", b0.uart_tx_o, 1);
    chk("arst_level", b0.uart_level_o, 0);
    chk("arst_ovf", b0.uart_ovf_o, 0);
    chk("arst_busy", b0.uart_busy_o, 0);
    chk("arst_empty", b0.uart_empty_o, 1);
    repeat (2) @(negedge sys_clk_i);
    sys_rst_ni = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk_i);
      if (b0.uart_tx_o !== 1'b1) lows++;
    end
    chk("post_rst_quiet", lows, 0);
    chk("post_rst_level", b0.uart_level_o, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO, for debug/telemetry output on the CSI-2 receiver test boards. It replaces the fixed 12 MHz / 3 Mbaud, 8N1, single-byte transmitter. It is generalised in clock/baud ratio, data width, parity and stop bits, and buffers up to FIFO_DEPTH words so producers can burst without polling busy. Frames go out back-to-back while the FIFO holds data.

## Interface
- CLK_HZ, 12000000: sys_clk_i frequency in Hz.
- BAUD, 3000000: line rate; BAUD <= CLK_HZ/2 required.
- DATA_BITS, 8: payload bits per frame, 5..9.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries, power of two, >= 2.
- sys_clk_i  in  1  system clock.
- sys_rst_ni  in  1  reset, asynchronous assert, active-low.
- uart_wr_i  in  1  write strobe; accepted when uart_full_o == 0.
- uart_dat_i  in  DATA_BITS  word to send; LSB is transmitted first.
- uart_full_o  out  1  FIFO full; writes are dropped.
- uart_empty_o  out  1  FIFO empty.
- uart_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH.
- uart_busy_o  out  1  frame in progress or FIFO non-empty.
- uart_ovf_o  out  1  sticky: a write was dropped while full; cleared only by reset.
- uart_tx_o  out  1  serial line, idle high.

## Operation
- Baud generator: free-running phase accumulator, unsigned, width $clog2(CLK_HZ)+1.
  - Each cycle: if acc + BAUD >= CLK_HZ, then acc <= acc + BAUD - CLK_HZ and tick = 1; else acc <= acc + BAUD and tick = 0.
  - The accumulator runs regardless of the transmit state. Long-run tick rate is exactly BAUD, with jitter of at most 1 cycle.
- FIFO: circular buffer with read/write pointers one bit wider than the address; the wrap bit distinguishes full from empty.
  - Push when uart_wr_i && !uart_full_o.
  - uart_wr_i && uart_full_o sets uart_ovf_o, and the data is lost.
  - Full/empty come from registered pointers. A write while full is rejected even if a pop occurs in the same cycle.
- Frame = 1 start bit (0), DATA_BITS data bits LSB first, an optional parity bit, then STOP_BITS stop bits (1).
  - NBITS = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.
  - Parity: even = XOR of the data bits; odd = its inverse.
- FSM states are IDLE and SEND.
  - IDLE: uart_tx_o = 1. On a tick with the FIFO non-empty: pop the head, load the shifter with {stop bits, parity, data, 0}, set bitcnt = NBITS, drive the start bit, go to SEND.
  - SEND: on each tick, shift the next bit onto uart_tx_o and decrement bitcnt.
  - When the final stop bit has lasted one full bit time (the tick where bitcnt reaches 0): if the FIFO is non-empty, pop and start the next frame's start bit on that same tick (no idle gap). Otherwise go to IDLE.
- uart_busy_o = (state == SEND) || !uart_empty_o.

## Timing
- Reset values: uart_tx_o = 1, uart_busy_o = 0, uart_full_o = 0, uart_empty_o = 1, uart_level_o = 0, uart_ovf_o = 0, acc = 0, state IDLE.
- uart_tx_o is a register output and changes only in the cycle after a tick.
- Write to status: uart_level_o, uart_empty_o and uart_full_o update the cycle after an accepted write.
- Write to start bit: the start bit begins 1 cycle after the first tick following the write, which is at most ceil(CLK_HZ/BAUD)+1 cycles later.
- Pop and push in the same cycle leave the level unchanged.
- Reset asserted mid-frame: the line returns high immediately (asynchronously), and the FIFO contents are discarded.
- A partial frame after reset is never resumed.

## Test plan
- Defaults, write 8'hA5 once -> uart_tx_o holds each bit for exactly 4 cycles, giving 0,1,0,1,0,0,1,0,1,1. uart_busy_o falls 40 cycles after the start bit begins; level goes 1 -> 0 at the start bit.
- Defaults, burst-write 20 words on consecutive cycles -> 16 accepted, uart_full_o high after the 16th, uart_ovf_o = 1. Exactly 16 frames are emitted back-to-back with no idle high between stop and start bits.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, write 7'h55 -> frame 0,1,0,1,0,1,0,1,0(parity),1,1, 11 bits long. With PARITY=1 the parity bit is 1.
- CLK_HZ=12000000, BAUD=115200, single byte -> intervals between line transitions are 104 or 105 cycles; the 10-bit frame spans 1041-1042 cycles.
- Assert sys_rst_ni low mid-frame with 3 words queued -> uart_tx_o = 1 immediately, level = 0, ovf = 0. After release, nothing is transmitted until a new write.
